instr_register_alu: RTL and testbench

Parametrised next-generation instruction register: an N-entry storage array of {opcode, operand_a, operand_b, result} words. Each word's result is computed by an integrated signed ALU at write time, and each entry carries a valid flag and a divide-error flag. It supports explicit or auto-incrementing write addressing and a registered read port. It sits between the stimulus interface (testbench or decoder) and downstream checkers/consumers.

---
 rtl/instr_register_alu.sv | 139 +++++++++++++
 tb/tb_instr_register_alu.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_register_alu.sv
// Instruction register: DEPTH entries of {opcode, operand_a, operand_b, result}, where the
// result comes from a signed ALU evaluated at write time. Reads have one cycle of latency.
module instr_register_alu #(
    parameter  int OP_WIDTH = 32,
    parameter  int DEPTH    = 32,
    parameter  int AUTO_PTR = 0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_en,
    input  logic                  clear_en,
    input  logic [OP_WIDTH-1:0]   operand_a,
    input  logic [OP_WIDTH-1:0]   operand_b,
    input  logic [2:0]            opcode,
    input  logic [AW-1:0]         write_pointer,
    input  logic                  read_en,
    input  logic [AW-1:0]         read_pointer,
    output logic [2:0]            iw_opcode,
    output logic [OP_WIDTH-1:0]   iw_operand_a,
    output logic [OP_WIDTH-1:0]   iw_operand_b,
    output logic [2*OP_WIDTH-1:0] iw_result,
    output logic                  iw_valid,
    output logic                  iw_div_err,
    output logic [AW-1:0]         wr_ptr_q,
    output logic [AW:0]           count,
    output logic                  full
);
    localparam int RW = 2 * OP_WIDTH;

    // Strobe semantics: load_en, clear_en and read_en each act on the single rising edge they are
    // high at. There is no back-pressure, so every strobe is accepted.
    logic [2:0]          op_q  [DEPTH];
    logic [OP_WIDTH-1:0] a_q   [DEPTH];
    logic [OP_WIDTH-1:0] b_q   [DEPTH];
    logic [RW-1:0]       res_q [DEPTH];
    logic [DEPTH-1:0]    valid_q;
    logic [DEPTH-1:0]    err_q;
    logic [AW:0]         count_q;
    logic [AW:0]         count_d;
    logic [AW-1:0]       wr_addr;

    logic signed [RW-1:0] a_ext;
    logic signed [RW-1:0] b_ext;
    logic signed [RW-1:0] alu_res;
    logic                 alu_err;

    assign a_ext   = {{OP_WIDTH{operand_a[OP_WIDTH-1]}}, operand_a};
    assign b_ext   = {{OP_WIDTH{operand_b[OP_WIDTH-1]}}, operand_b};
    assign wr_addr = (AUTO_PTR != 0) ? wr_ptr_q : write_pointer;
    assign count   = count_q;
    assign full    = (count_q == (AW+1)'(DEPTH));

    // Operands are widened to 2*OP_WIDTH before any operation, so products and the
    // most-negative / -1 quotient are exact.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (opcode)
            3'd0: alu_res = '0;
            3'd1: alu_res = a_ext;
            3'd2: alu_res = b_ext;
            3'd3: alu_res = a_ext + b_ext;
            3'd4: alu_res = a_ext - b_ext;
            3'd5: alu_res = a_ext * b_ext;
            3'd6: begin
                if (b_ext == '0) alu_err = 1'b1;
                else             alu_res = a_ext / b_ext;
            end
            3'd7: begin
                if (b_ext == '0) alu_err = 1'b1;
                else             alu_res = a_ext % b_ext;
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (clear_en)
            count_d = '0;
        else if (load_en && !valid_q[wr_addr])
            count_d = count_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]  <= '0;
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                res_q[i] <= '0;
            end
            valid_q      <= '0;
            err_q        <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            iw_opcode    <= '0;
            iw_operand_a <= '0;
            iw_operand_b <= '0;
            iw_result    <= '0;
            iw_valid     <= 1'b0;
            iw_div_err   <= 1'b0;
        end else begin
            // The read samples the array before this edge's write or clear, giving read-before-write.
            if (read_en) begin
                if (valid_q[read_pointer]) begin
                    iw_opcode    <= op_q[read_pointer];
                    iw_operand_a <= a_q[read_pointer];
                    iw_operand_b <= b_q[read_pointer];
                    iw_result    <= res_q[read_pointer];
                    iw_valid     <= 1'b1;
                    iw_div_err   <= err_q[read_pointer];
                end else begin
                    iw_opcode    <= '0;
                    iw_operand_a <= '0;
                    iw_operand_b <= '0;
                    iw_result    <= '0;
                    iw_valid     <= 1'b0;
                    iw_div_err   <= 1'b0;
                end
            end
            if (clear_en) begin
                valid_q <= '0;
            end else if (load_en) begin
                op_q[wr_addr]    <= opcode;
                a_q[wr_addr]     <= operand_a;
                b_q[wr_addr]     <= operand_b;
                res_q[wr_addr]   <= alu_res;
                valid_q[wr_addr] <= 1'b1;
                err_q[wr_addr]   <= alu_err;
            end
            // The pointer advances on a discarded write too; DEPTH is a power of two, so it wraps.
            if (load_en)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_instr_register_alu.sv
// Bench for instr_register_alu: one explicit-address instance (DEPTH 8) and one auto-pointer
// instance (DEPTH 4), checked against an array-based reference model of the register file.
module tb_instr_register_alu;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // Instance 0: explicit write address, DEPTH 8
    logic        ld0, clr0, rd0;
    logic [2:0]  op0, wp0, rp0;
    logic [31:0] a0, b0;
    logic [2:0]  o_op0;
    logic [31:0] o_a0, o_b0;
    logic [63:0] o_res0;
    logic        o_v0, o_e0, o_full0;
    logic [2:0]  o_wp0;
    logic [3:0]  o_cnt0;

    // Instance 1: auto pointer, DEPTH 4
    logic        ld1, clr1, rd1;
    logic [2:0]  op1;
    logic [1:0]  wp1, rp1;
    logic [31:0] a1, b1;
    logic [2:0]  o_op1;
    logic [31:0] o_a1, o_b1;
    logic [63:0] o_res1;
    logic        o_v1, o_e1, o_full1;
    logic [1:0]  o_wp1;
    logic [2:0]  o_cnt1;

    instr_register_alu #(.OP_WIDTH(32), .DEPTH(8), .AUTO_PTR(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .load_en(ld0), .clear_en(clr0),
        .operand_a(a0), .operand_b(b0), .opcode(op0), .write_pointer(wp0),
        .read_en(rd0), .read_pointer(rp0), .iw_opcode(o_op0), .iw_operand_a(o_a0),
        .iw_operand_b(o_b0), .iw_result(o_res0), .iw_valid(o_v0), .iw_div_err(o_e0),
        .wr_ptr_q(o_wp0), .count(o_cnt0), .full(o_full0));

    instr_register_alu #(.OP_WIDTH(32), .DEPTH(4), .AUTO_PTR(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .load_en(ld1), .clear_en(clr1),
        .operand_a(a1), .operand_b(b1), .opcode(op1), .write_pointer(wp1),
        .read_en(rd1), .read_pointer(rp1), .iw_opcode(o_op1), .iw_operand_a(o_a1),
        .iw_operand_b(o_b1), .iw_result(o_res1), .iw_valid(o_v1), .iw_div_err(o_e1),
        .wr_ptr_q(o_wp1), .count(o_cnt1), .full(o_full1));

    int checks = 0;
    int errors = 0;

    // Reference model: contents of each register file plus the expected read outputs
    int          dep [2] = '{8, 4};
    logic [2:0]  m_op  [2][8];
    logic [31:0] m_a   [2][8];
    logic [31:0] m_b   [2][8];
    logic [63:0] m_res [2][8];
    bit          m_v   [2][8];
    bit          m_e   [2][8];
    int          m_wp  [2];
    logic [2:0]  e_op  [2];
    logic [31:0] e_a   [2];
    logic [31:0] e_b   [2];
    logic [63:0] e_res [2];
    bit          e_v   [2];
    bit          e_e   [2];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          addr;
        logic [63:0] res;
        logic        err;
    } vec_t;
    vec_t vt [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, output bit err);
        int     ia = a;
        int     ib = b;
        longint la = ia;
        longint lb = ib;
        err = 1'b0;
        case (op)
            3'd1: return la;
            3'd2: return lb;
            3'd3: return la + lb;
            3'd4: return la - lb;
            3'd5: return la * lb;
            3'd6: begin
                if (lb == 0) begin err = 1'b1; return 0; end
                return la / lb;
            end
            3'd7: begin
                if (lb == 0) begin err = 1'b1; return 0; end
                return la % lb;
            end
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                m_op[d][i] = '0; m_a[d][i] = '0; m_b[d][i] = '0;
                m_res[d][i] = '0; m_v[d][i] = 0; m_e[d][i] = 0;
            end
            m_wp[d] = 0;
            e_op[d] = '0; e_a[d] = '0; e_b[d] = '0; e_res[d] = '0; e_v[d] = 0; e_e[d] = 0;
        end
    endtask

    task automatic check_dut(input int d);
        logic [2:0]  aop;
        logic [31:0] aa, ab;
        logic [63:0] ares;
        logic        av, ae, afull;
        int          awp, acnt, cnt;
        if (d == 0) begin
            aop = o_op0; aa = o_a0; ab = o_b0; ares = o_res0; av = o_v0; ae = o_e0;
            afull = o_full0; awp = int'(o_wp0); acnt = int'(o_cnt0);
        end else begin
            aop = o_op1; aa = o_a1; ab = o_b1; ares = o_res1; av = o_v1; ae = o_e1;
            afull = o_full1; awp = int'(o_wp1); acnt = int'(o_cnt1);
        end
        cnt = 0;
        for (int i = 0; i < dep[d]; i++) cnt += int'(m_v[d][i]);
        chk($sformatf("count%0d", d), 64'(acnt), 64'(cnt));
        chk($sformatf("full%0d", d), 64'(afull), 64'(cnt == dep[d]));
        chk($sformatf("wr_ptr%0d", d), 64'(awp), 64'(m_wp[d]));
        chk($sformatf("iw_opcode%0d", d), 64'(aop), 64'(e_op[d]));
        chk($sformatf("iw_operand_a%0d", d), 64'(aa), 64'(e_a[d]));
        chk($sformatf("iw_operand_b%0d", d), 64'(ab), 64'(e_b[d]));
        chk($sformatf("iw_result%0d", d), ares, e_res[d]);
        chk($sformatf("iw_valid%0d", d), 64'(av), 64'(e_v[d]));
        chk($sformatf("iw_div_err%0d", d), 64'(ae), 64'(e_e[d]));
    endtask

    // Drive one cycle on instance d (the other idles), advance the model and compare
    task automatic step(input int d, input bit ld, input bit clr, input bit rd,
                        input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int wp, input int rp);
        int r, addr;
        bit err;
        @(negedge clk);
        ld0 = 0; clr0 = 0; rd0 = 0; ld1 = 0; clr1 = 0; rd1 = 0;
        if (d == 0) begin
            ld0 = ld; clr0 = clr; rd0 = rd; op0 = op; a0 = a; b0 = b;
            wp0 = 3'(wp); rp0 = 3'(rp);
        end else begin
            ld1 = ld; clr1 = clr; rd1 = rd; op1 = op; a1 = a; b1 = b;
            wp1 = 2'(wp); rp1 = 2'(rp);
        end
        @(posedge clk);
        r = rp % dep[d];
        if (rd) begin
            if (m_v[d][r]) begin
                e_op[d] = m_op[d][r]; e_a[d] = m_a[d][r]; e_b[d] = m_b[d][r];
                e_res[d] = m_res[d][r]; e_v[d] = 1; e_e[d] = m_e[d][r];
            end else begin
                e_op[d] = '0; e_a[d] = '0; e_b[d] = '0; e_res[d] = '0; e_v[d] = 0; e_e[d] = 0;
            end
        end
        addr = (d == 1) ? m_wp[d] : wp % dep[d];
        if (clr) begin
            for (int i = 0; i < 8; i++) m_v[d][i] = 0;
        end else if (ld) begin
            m_res[d][addr] = ref_alu(op, a, b, err);
            m_op[d][addr] = op; m_a[d][addr] = a; m_b[d][addr] = b;
            m_v[d][addr] = 1; m_e[d][addr] = err;
        end
        if (ld) m_wp[d] = (m_wp[d] + 1) % dep[d];
        #1;
        check_dut(d);
    endtask

    // Reset dropped mid-cycle while a write and a read are being driven
    task automatic do_reset();
        @(negedge clk);
        ld0 = 1; rd0 = 1; ld1 = 1; rd1 = 1;
        #2 reset_n = 0;
        #1;
        model_reset();
        check_dut(0);
        check_dut(1);
        @(negedge clk);
        reset_n = 1;
        ld0 = 0; rd0 = 0; ld1 = 0; rd1 = 0;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1, 2:    return $urandom;
            default: return 32'($urandom_range(0, 40)) - 32'd20;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0;
        ld0 = 0; clr0 = 0; rd0 = 0; op0 = '0; a0 = '0; b0 = '0; wp0 = '0; rp0 = '0;
        ld1 = 0; clr1 = 0; rd1 = 0; op1 = '0; a1 = '0; b1 = '0; wp1 = '0; rp1 = '0;
        model_reset();

        vt[0]  = '{3'd3, -32'sd5,       32'sd7,        3, 64'sd2,                 1'b0};
        vt[1]  = '{3'd5, 32'h7FFF_FFFF, 32'd2,         4, 64'hFFFF_FFFE,          1'b0};
        vt[2]  = '{3'd6, 32'd10,        32'd0,         0, 64'd0,                  1'b1};
        vt[3]  = '{3'd7, -32'sd7,       32'sd3,        5, -64'sd1,                1'b0};
        vt[4]  = '{3'd6, -32'sd7,       32'sd2,        6, -64'sd3,                1'b0};
        vt[5]  = '{3'd7, 32'sd7,        -32'sd3,       7, 64'sd1,                 1'b0};
        vt[6]  = '{3'd4, 32'sd3,        32'sd10,       2, -64'sd7,                1'b0};
        vt[7]  = '{3'd5, 32'h8000_0000, 32'h8000_0000, 1, 64'h4000_0000_0000_0000, 1'b0};
        vt[8]  = '{3'd2, 32'd1,         -32'sd1,       1, -64'sd1,                1'b0};
        vt[9]  = '{3'd7, 32'd5,         32'd0,         0, 64'd0,                  1'b1};
        vt[10] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 3, 64'h8000_0000,          1'b0};
        vt[11] = '{3'd0, 32'd5,         32'd6,         2, 64'd0,                  1'b0};

        repeat (2) @(negedge clk);
        check_dut(0);
        check_dut(1);
        reset_n = 1;

        // Reset after five writes, then read an address that was written before reset
        for (int i = 0; i < 5; i++)
            step(0, 1, 0, 0, 3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), i, 0);
        step(0, 0, 0, 1, 3'd0, 0, 0, 0, 2);
        do_reset();
        chk("rst_count", 64'(o_cnt0), 64'd0);
        chk("rst_wr_ptr", 64'(o_wp0), 64'd0);
        chk("rst_iw_result", o_res0, 64'd0);
        step(0, 0, 0, 1, 3'd0, 0, 0, 0, 2);
        chk("rst_read_valid", 64'(o_v0), 64'd0);

        // ALU vectors: write each at its address, then read it back
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 0, 0, vt[i].op, vt[i].a, vt[i].b, vt[i].addr, 0);
            step(0, 0, 0, 1, 3'd0, 0, 0, 0, vt[i].addr);
            chk($sformatf("vec%0d_result", i), o_res0, vt[i].res);
            chk($sformatf("vec%0d_div_err", i), 64'(o_e0), 64'(vt[i].err));
            chk($sformatf("vec%0d_opcode", i), 64'(o_op0), 64'(vt[i].op));
            chk($sformatf("vec%0d_valid", i), 64'(o_v0), 64'd1);
        end

        // Auto pointer wrap on the DEPTH-4 instance
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            step(1, 1, 0, 0, 3'd1, 32'(i), 32'd0, 0, 0);
            if (i == 4) chk("wrap_full_after4", 64'(o_full1), 64'd1);
        end
        chk("wrap_wr_ptr_after5", 64'(o_wp1), 64'd1);
        step(1, 0, 0, 1, 3'd0, 0, 0, 0, 0);
        chk("wrap_read_a", 64'(o_a1), 64'd5);
        chk("wrap_count", 64'(o_cnt1), 64'd4);

        // Read-before-write collision on address 1
        step(0, 1, 0, 0, 3'd2, 0, 32'd9, 1, 0);
        step(0, 1, 0, 1, 3'd2, 0, 32'd4, 1, 1);
        chk("rbw_old_value", o_res0, 64'd9);
        step(0, 0, 0, 1, 3'd0, 0, 0, 0, 1);
        chk("rbw_new_value", o_res0, 64'd4);

        // Clear beats a simultaneous write; the pointer still advances
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 3'd3, 32'(i), 32'd1, i, 0);
        chk("clr_count_before", 64'(o_cnt0), 64'd3);
        step(0, 1, 1, 1, 3'd1, 32'd77, 0, 5, 1);
        chk("clr_count", 64'(o_cnt0), 64'd0);
        chk("clr_wr_ptr", 64'(o_wp0), 64'd4);
        chk("clr_read_pre_clear", 64'(o_v0), 64'd1);
        step(0, 0, 0, 1, 3'd0, 0, 0, 0, 5);
        chk("clr_discarded_write", 64'(o_v0), 64'd0);

        // Randomized traffic on both instances
        for (int n = 0; n < 800; n++) begin
            step(n % 2, $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                 rnd_operand(), rnd_operand(), $urandom_range(0, 7), $urandom_range(0, 7));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
